// File: rtl/seq_det_pkg.sv
// Shared types and constants for the round-robin "1010" detector.
package seq_det_pkg;

  // Per-channel detector progress through the pattern.
  typedef enum logic [1:0] {
    S0 = 2'd0,  // nothing matched
    S1 = 2'd1,  // "1"
    S2 = 2'd2,  // "10"
    S3 = 2'd3   // "101"
  } state_e;

  // Pattern recognised by the detector, oldest bit first.
  localparam logic [3:0] Pattern = 4'b1010;

endpackage

// File: rtl/seq_det_step.sv
// One combinational step of the overlapping "1010" Mealy detector.
module seq_det_step
  import seq_det_pkg::*;
(
  input  state_e state,
  input  logic   x,
  output state_e next_state,
  output logic   z
);

  // Transition table; S3 on a 0 falls back to S2 so "10" can start the next match.
  always_comb begin
    next_state = S0;
    z          = 1'b0;
    unique case (state)
      S0: next_state = x ? S1 : S0;
      S1: next_state = x ? S1 : S2;
      S2: next_state = x ? S3 : S0;
      S3: begin
        next_state = x ? S1 : S2;
        z          = ~x;
      end
      default: next_state = S0;
    endcase
  end

endmodule

// File: rtl/seq_det_rr_sched.sv
// Round-robin scheduler sharing one "1010" detector step among NCH serial channels.
module seq_det_rr_sched
  import seq_det_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned IdxW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   x_valid,
  input  logic [NCH-1:0]   x,
  output logic [NCH-1:0]   x_ready,
  input  logic [NCH-1:0]   clr,
  output logic             z_valid,
  output logic [IdxW-1:0]  z_ch,
  output logic             z,
  input  logic [IdxW-1:0]  cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  state_e            state_q [NCH];
  logic [CNT_W-1:0]  cnt_q   [NCH];
  logic [IdxW-1:0]   rr_ptr;

  logic [NCH-1:0]    eligible;
  logic              gnt_vld;
  logic [IdxW-1:0]   gnt_idx;
  int unsigned       idx;

  state_e            step_state;
  state_e            step_next;
  logic              step_bit;
  logic              step_z;

  // Priority search starting at rr_ptr; a cleared channel is never eligible.
  always_comb begin
    eligible = x_valid & ~clr;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    idx      = 0;
    x_ready  = '0;
    for (int unsigned off = 0; off < NCH; off++) begin
      idx = (32'(rr_ptr) + off) % NCH;
      if (!gnt_vld && eligible[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IdxW'(idx);
      end
    end
    // Hold the grant low while reset is asserted.
    if (gnt_vld && rst_n) begin
      x_ready[gnt_idx] = 1'b1;
    end
  end

  // Feed the shared detector step with the granted channel's context.
  always_comb begin
    step_state = state_q[gnt_idx];
    step_bit   = x[gnt_idx];
  end

  seq_det_step u_step (
    .state      (step_state),
    .x          (step_bit),
    .next_state (step_next),
    .z          (step_z)
  );

  // Per-channel contexts: clear beats acceptance, counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          state_q[i] <= S0;
          cnt_q[i]   <= '0;
        end else if (gnt_vld && (gnt_idx == IdxW'(i))) begin
          state_q[i] <= step_next;
          if (step_z && (cnt_q[i] != '1)) begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Round-robin pointer moves past the last winner; holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == IdxW'(NCH - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
  end

  // Registered result of the bit processed this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_valid <= 1'b0;
      z       <= 1'b0;
      z_ch    <= '0;
    end else begin
      z_valid <= gnt_vld;
      z       <= gnt_vld & step_z;
      if (gnt_vld) begin
        z_ch <= gnt_idx;
      end
    end
  end

  // Counter read port; out-of-range selects read as zero.
  always_comb begin
    cnt_out = '0;
    if (32'(cnt_sel) < NCH) begin
      cnt_out = cnt_q[cnt_sel];
    end
  end

endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Directed, table-driven bench for seq_det_rr_sched (NCH=4, CNT_W=2).
module tb_seq_det_rr_sched;
  import seq_det_pkg::*;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   x_valid;
  logic [NCH-1:0]   x;
  logic [NCH-1:0]   x_ready;
  logic [NCH-1:0]   clr;
  logic             z_valid;
  logic [1:0]       z_ch;
  logic             z;
  logic [1:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_out;

  int checks   = 0;
  int failures = 0;

  seq_det_rr_sched #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x_valid (x_valid),
    .x       (x),
    .x_ready (x_ready),
    .clr     (clr),
    .z_valid (z_valid),
    .z_ch    (z_ch),
    .z       (z),
    .cnt_sel (cnt_sel),
    .cnt_out (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the expected outcome after its edge.
  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] xb;
    logic [3:0] clrv;
    logic [3:0] rdy;
    logic       zv;
    logic       zz;
    logic [1:0] zch;
    logic [1:0] sel;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] xb,
                              input logic [3:0] clrv, input logic [3:0] rdy,
                              input logic zv, input logic zz, input logic [1:0] zch,
                              input logic [1:0] sel, input logic [1:0] cnt);
    vec_t v;
    v.valid = valid; v.xb = xb; v.clrv = clrv; v.rdy = rdy;
    v.zv = zv; v.zz = zz; v.zch = zch; v.sel = sel; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic apply(input string nm, input vec_t v);
    x_valid = v.valid;
    x       = v.xb;
    clr     = v.clrv;
    cnt_sel = v.sel;
    @(negedge clk);
    chk({nm, ".x_ready"}, 32'(x_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    chk({nm, ".z_valid"}, 32'(z_valid), 32'(v.zv));
    if (v.zv) begin
      chk({nm, ".z"}, 32'(z), 32'(v.zz));
      chk({nm, ".z_ch"}, 32'(z_ch), 32'(v.zch));
    end
    chk({nm, ".cnt_out"}, 32'(cnt_out), 32'(v.cnt));
  endtask

  task automatic run_tbl(input string nm);
    foreach (tbl[i]) apply($sformatf("%s[%0d]", nm, i), tbl[i]);
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] xr [4];
    int         m;
    xr[0] = 4'b0111; xr[1] = 4'b1010; xr[2] = 4'b0100; xr[3] = 4'b1000;

    // Reset: outputs and counters zero, no grant even with requests pending.
    rst_n = 1'b0; x_valid = 4'hF; x = 4'h0; clr = 4'h0; cnt_sel = 2'd0;
    #12;
    chk("rst.x_ready", 32'(x_ready), 32'h0);
    chk("rst.z_valid", 32'(z_valid), 32'h0);
    chk("rst.z", 32'(z), 32'h0);
    chk("rst.z_ch", 32'(z_ch), 32'h0);
    for (int s = 0; s < NCH; s++) begin
      cnt_sel = 2'(s);
      #1;
      chk($sformatf("rst.cnt%0d", s), 32'(cnt_out), 32'h0);
    end
    @(negedge clk);
    x_valid = 4'h0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Channel 0 alone: 101010 gives two overlapping matches.
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 4'h1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 4'h1, 1, 1, 0, 0, 2));
    tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 0, 0, 0, 0, 0));
    run_tbl("single");

    // rr_ptr is 1: a lone ch3 grant brings it back to 0.
    tbl.push_back(mk(4'h8, 4'h0, 4'h0, 4'h8, 1, 0, 3, 2, 0));
    // All channels valid: strict rotation; only ch2 carries "1010".
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        tbl.push_back(mk(4'hF, xr[k], 4'h0, 4'(1 << c), 1, (k == 3 && c == 2),
                         2'(c), 2'd2, 2'((k == 3 && c >= 2) ? 1 : 0)));
      end
    end
    tbl.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 0, 0, 0, 2, 0));
    run_tbl("rotate");

    // ch0 sends "10", ch1 runs 8 bits, ch0 finishes "10": ch0 context kept.
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0, 0));
    m = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= 3 && i % 2 == 1) m++;
      tbl.push_back(mk(4'h2, (i % 2 == 0) ? 4'h2 : 4'h0, 4'h0, 4'h2, 1,
                       (i >= 3 && i % 2 == 1), 1, 1, 2'(m)));
    end
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 4'h1, 1, 1, 0, 0, 1));
    run_tbl("interleave");

    // ch1 to S3 (cnt 3), then clr with bit pending: no grant, context wiped.
    tbl.push_back(mk(4'h2, 4'h2, 4'h0, 4'h2, 1, 0, 1, 1, 3));
    tbl.push_back(mk(4'h2, 4'h0, 4'h2, 4'h0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(4'h3, 4'h0, 4'h2, 4'h1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(4'h2, 4'h0, 4'h0, 4'h2, 1, 0, 1, 1, 0));
    run_tbl("clear");

    // Five matches on ch3 with a 2-bit counter: z keeps pulsing, count sticks at 3.
    m = 0;
    for (int i = 0; i < 12; i++) begin
      if (i >= 3 && i % 2 == 1) m++;
      tbl.push_back(mk(4'h8, (i % 2 == 0) ? 4'h8 : 4'h0, 4'h0, 4'h8, 1,
                       (i >= 3 && i % 2 == 1), 3, 3, 2'((m > 3) ? 3 : m)));
    end
    run_tbl("saturate");

    // ch0 to S3, then asynchronous reset between edges.
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0, 1));
    run_tbl("prerst");
    x_valid = 4'h1; x = 4'h0; clr = 4'h0; cnt_sel = 2'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.z_valid", 32'(z_valid), 32'h0);
    chk("arst.z_ch", 32'(z_ch), 32'h0);
    chk("arst.x_ready", 32'(x_ready), 32'h0);
    chk("arst.cnt_out", 32'(cnt_out), 32'h0);
    @(negedge clk);
    x_valid = 4'h0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.idle_z_valid", 32'(z_valid), 32'h0);
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 4'h1, 1, 1, 0, 0, 1));
    run_tbl("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det_rr_sched.md
# seq_det_rr_sched

Round-robin scheduler that shares one overlapping "1010" Mealy detection step among NCH serial bit channels. Each channel keeps its own saved detector state and a saturating match counter. Each cycle the block grants at most one pending bit and advances only that channel's context. It sits between the serial front-end channels and the status/interrupt logic, replacing one standalone detector instance per channel.

## Interface
- NCH, 4, number of serial channels (2..8)
- CNT_W, 8, width of per-channel match counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- x_valid  in  NCH  channel i has a bit pending
- x  in  NCH  bit value per channel
- x_ready  out  NCH  one-hot (or zero) grant; bit accepted when x_valid[i] & x_ready[i]
- clr  in  NCH  synchronous per-channel context clear
- z_valid  out  1  registered: a bit was processed last cycle
- z_ch  out  $clog2(NCH)  channel processed last cycle
- z  out  1  registered Mealy output for that bit (1 = "1010" completed)
- cnt_sel  in  $clog2(NCH)  counter read select
- cnt_out  out  CNT_W  match count of channel cnt_sel (combinational read)

## Operation
- Per-channel state, 2 bits: S0 (nothing), S1 ("1"), S2 ("10"), S3 ("101").
- Transitions (x=0 / x=1):
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S0 / S3
  - S3 -> S2 with z=1 / S1
- z=1 only on S3 with x=0; the S2 target keeps overlap, so "1010" followed by "10" matches again.
- Arbitration: the eligible set is x_valid & ~clr. Search starts at rr_ptr and increments modulo NCH. The first eligible channel gets x_ready. At most one x_ready bit is high per cycle.
- After a grant to channel g, rr_ptr <= (g+1) mod NCH. With no grant, rr_ptr holds.
- Accepted bit: state[g] <= next state. On z=1, cnt[g] <= cnt[g]+1, saturating at 2^CNT_W-1.
- clr[i]: state[i] <= S0 and cnt[i] <= 0 at the next edge. A cleared channel is not eligible that cycle, and its bit stays pending for the sender.
- Non-granted channels keep their state and count unchanged; their bits wait (x_valid held by the sender).

## Timing
- Reset values: all state S0, all cnt 0, rr_ptr 0, z_valid 0, z 0, z_ch 0. x_ready=0 while in reset.
- x_ready is combinational from x_valid, clr and rr_ptr. There is no combinational path from x to x_ready.
- Latency: a bit accepted at edge N produces z_valid/z/z_ch valid in cycle N+1. z_valid is a single-cycle pulse per accepted bit.
- cnt_out reflects the count after the edge, so an increment is visible the cycle after acceptance.
- Throughput: 1 bit/cycle aggregate. Worst-case wait for a continuously valid channel is NCH-1 cycles.
- When clr and acceptance would hit the same channel in the same cycle, clr wins and no grant is made to that channel. Another eligible channel may still be granted.
- If rst_n is asserted mid-stream, everything clears immediately (asynchronously). A pending z_valid is dropped.
- When cnt is saturated, further matches still pulse z=1 but the count holds.

## Structure
- Package seq_det_pkg holds:
  - state enum {S0,S1,S2,S3} (2-bit)
  - the detected pattern constant 4'b1010 for documentation and test use
- Sub-module seq_det_step: purely combinational (state, x) -> (next_state, z). It is instantiated once and driven by a mux of the granted channel's state.
- Top level contains the state and count register arrays, the round-robin pointer with the priority search, the output registers and the counter read mux.

## Test plan
- Reset then single channel 0: x = 1,0,1,0,1,0 on consecutive grants -> z = 0,0,0,1,0,1 (overlap); cnt_out(sel 0) = 2.
- All four channels valid every cycle -> grants rotate 0,1,2,3,0,...; each channel's z matches its own stream independently. Send "1010" on ch2 only -> z=1 with z_ch=2 only.
- Interleaving check: ch0 sends "10" and then stalls while ch1 runs 8 bits; ch0 then sends "10" -> the match is detected on ch0 (its context was preserved).
- clr[1] asserted while x_valid[1]=1 and ch1 is in S3 -> no grant to ch1 that cycle; next bit x=0 gives z=0 and cnt[1]=0.
- Saturation with CNT_W=2: 5 matches on ch3 -> cnt_out=3, with z still pulsing on each match.
- Assert rst_n=0 asynchronously between edges with ch0 in S3 -> outputs zero immediately. After release, "0" gives z=0 and "1010" gives z=1.
